// File: rtl/v_ex_1.sv
// ---------------------------------------------------------------------------
// v_ex_1 : vector execute stage
//
// Sits directly behind vector decode. Accepts one decoded vector instruction
// when idle and produces a registered one-cycle writeback pulse for the
// vector register file.
//   VADD : lane-wise EW-bit add, result written back one cycle after accept.
//   VMUL : lane-serial multiply, MUL_LANES lanes per cycle over N cycles,
//          result written back the cycle after the last multiply cycle.
//   other opcodes : accepted and dropped, no writeback.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   vex_valid_i       decoded instruction valid
//   vex_ready_o       stage idle and able to accept
//   valu_opcode_i     ALU opcode (0 NOP, 1 VADD, 2 VMUL, others NOP)
//   operand_v1_i/v2_i operand vectors
//   vid_wb_en_i       instruction writes a vector register
//   vid_wb_addr_i     destination register
//   vex_wb_en_o       one-cycle writeback strobe
//   vex_wb_addr_o     writeback register address (holds between strobes)
//   vex_wb_data_o     writeback data (holds between strobes)
//   vex_busy_o        multiply in progress
//   vex_busy_cnt_o    multiply busy-cycle counter (VEX_PERF_CNT_EN only)
//
// Configuration macro: VEX_PERF_CNT_EN adds the busy-cycle counter port.
// ---------------------------------------------------------------------------
module v_ex_1 #(
    parameter int VLMAX     = 8,
    parameter int VALUOP_DW = 5,
    parameter int VREG_DW   = 256,
    parameter int VREG_AW   = 5,
    parameter int MUL_LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vex_valid_i,
    output logic                 vex_ready_o,
    input  logic [VALUOP_DW-1:0] valu_opcode_i,
    input  logic [VREG_DW-1:0]   operand_v1_i,
    input  logic [VREG_DW-1:0]   operand_v2_i,
    input  logic                 vid_wb_en_i,
    input  logic [VREG_AW-1:0]   vid_wb_addr_i,
    output logic                 vex_wb_en_o,
    output logic [VREG_AW-1:0]   vex_wb_addr_o,
    output logic [VREG_DW-1:0]   vex_wb_data_o,
    output logic                 vex_busy_o
`ifdef VEX_PERF_CNT_EN
    ,
    output logic [31:0]          vex_busy_cnt_o
`endif
);

    localparam int EW    = VREG_DW / VLMAX;
    localparam int N     = VLMAX / MUL_LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [VALUOP_DW-1:0] OP_VADD = VALUOP_DW'(1);
    localparam logic [VALUOP_DW-1:0] OP_VMUL = VALUOP_DW'(2);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [VREG_DW-1:0]   r_op1;
    logic [VREG_DW-1:0]   r_op2;
    logic [VREG_DW-1:0]   r_res;
    logic                 r_mul_wb_en;
    logic [VREG_AW-1:0]   r_mul_addr;
    logic                 r_wb_en;
    logic [VREG_AW-1:0]   r_wb_addr;
    logic [VREG_DW-1:0]   r_wb_data;
    logic                 w_wb_en_nxt;
    logic [VREG_AW-1:0]   w_wb_addr_nxt;
    logic [VREG_DW-1:0]   w_wb_data_nxt;
    logic                 w_op_load;
    logic                 w_accept;
    logic [VREG_DW-1:0]   w_add;
    logic [VREG_DW-1:0]   w_res_nxt;

    assign vex_ready_o   = (r_state == ST_IDLE);
    assign vex_busy_o    = (r_state == ST_MUL);
    assign vex_wb_en_o   = r_wb_en;
    assign vex_wb_addr_o = r_wb_addr;
    assign vex_wb_data_o = r_wb_data;
    assign w_accept      = vex_valid_i & vex_ready_o;

    // Lane-wise add of the incoming operands; carries out of each lane are dropped.
    always_comb begin
        w_add = '0;
        for (int i = 0; i < VLMAX; i++) begin
            w_add[i*EW +: EW] = operand_v1_i[i*EW +: EW] + operand_v2_i[i*EW +: EW];
        end
    end

    // Multiply the MUL_LANES lanes selected by the lane counter, keeping the low EW bits.
    always_comb begin
        w_res_nxt = r_res;
        for (int j = 0; j < MUL_LANES; j++) begin
            w_res_nxt[(int'(r_cnt) * MUL_LANES + j) * EW +: EW] =
                r_op1[(int'(r_cnt) * MUL_LANES + j) * EW +: EW] *
                r_op2[(int'(r_cnt) * MUL_LANES + j) * EW +: EW];
        end
    end

    // Next-state and writeback decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_wb_en_nxt   = 1'b0;
        w_wb_addr_nxt = r_wb_addr;
        w_wb_data_nxt = r_wb_data;
        w_op_load     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (valu_opcode_i)
                        OP_VADD: begin
                            // A non-writing VADD leaves the held writeback bus untouched.
                            if (vid_wb_en_i) begin
                                w_wb_en_nxt   = 1'b1;
                                w_wb_addr_nxt = vid_wb_addr_i;
                                w_wb_data_nxt = w_add;
                            end else begin
                                w_wb_en_nxt   = 1'b0;
                            end
                        end
                        OP_VMUL: begin
                            w_state_nxt = ST_MUL;
                            w_cnt_nxt   = '0;
                            w_op_load   = 1'b1;
                        end
                        default: begin
                            w_wb_en_nxt = 1'b0;
                        end
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    if (r_mul_wb_en) begin
                        w_wb_en_nxt   = 1'b1;
                        w_wb_addr_nxt = r_mul_addr;
                        w_wb_data_nxt = w_res_nxt;
                    end else begin
                        w_wb_en_nxt   = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, writeback and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_res       <= '0;
            r_mul_wb_en <= 1'b0;
            r_mul_addr  <= '0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wb_en   <= w_wb_en_nxt;
            r_wb_addr <= w_wb_addr_nxt;
            r_wb_data <= w_wb_data_nxt;
            if (w_op_load) begin
                r_op1       <= operand_v1_i;
                r_op2       <= operand_v2_i;
                r_mul_wb_en <= vid_wb_en_i;
                r_mul_addr  <= vid_wb_addr_i;
            end
            if (r_state == ST_MUL) begin
                r_res <= w_res_nxt;
            end
        end
    end

`ifdef VEX_PERF_CNT_EN
    logic [31:0] r_busy_cnt;
    assign vex_busy_cnt_o = r_busy_cnt;

    // Busy-cycle counter, free-running wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cnt <= 32'd0;
        end else if (r_state == ST_MUL) begin
            r_busy_cnt <= r_busy_cnt + 32'd1;
        end
    end
`endif

endmodule
